// File: rtl/ts_pkg.sv
// Shared types and constants for the MPEG-2 TS header scheduler slice.
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_HDR_BYTES = 4;

    // Field order matches the wire order of header bytes 1..3.
    typedef struct packed {
        logic        tei;
        logic        pusi;
        logic        prio;
        logic [12:0] pid;
        logic [1:0]  tsc;
        logic [1:0]  afc;
        logic [3:0]  cc;
    } ts_hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        B1,
        B2,
        B3,
        SKIP
    } cap_state_t;

    function automatic ts_hdr_t make_hdr(input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [7:0] b3);
        return ts_hdr_t'({b1, b2, b3});
    endfunction

endpackage

// File: rtl/ts_hdr_capture.sv
// Per-lane TS header capture: sync validation, 1-deep header holding register
// with overflow detection, and tick-based sync-loss supervision.
module ts_hdr_capture
    import ts_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sync,
    input  logic        tick,
    input  logic [15:0] timeout_limit,
    input  logic        grant,
    output logic        pending,
    output ts_hdr_t     hdr,
    output logic        sync_err,
    output logic        overflow,
    output logic        lane_timeout
);

    cap_state_t  state;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [15:0] tcount;
    logic        valid_sync;
    logic        complete;

    assign valid_sync = in_valid && in_sync && (in_data == TS_SYNC_BYTE);
    assign complete   = in_valid && !in_sync && (state == B3);

    // A sync beat overrides whatever partial header was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            b1       <= '0;
            b2       <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (in_valid && in_sync) begin
                if (in_data == TS_SYNC_BYTE) begin
                    state <= B1;
                end else begin
                    state    <= IDLE;
                    sync_err <= 1'b1;
                end
            end else if (in_valid) begin
                case (state)
                    B1: begin
                        b1    <= in_data;
                        state <= B2;
                    end
                    B2: begin
                        b2    <= in_data;
                        state <= B3;
                    end
                    B3:      state <= SKIP;
                    default: ;
                endcase
            end
        end
    end

    // A same-cycle grant frees the slot, so the new header may replace the old one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= 1'b0;
            hdr      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (complete) begin
                if (pending && !grant) begin
                    overflow <= 1'b1;
                end else begin
                    hdr     <= make_hdr(b1, b2, in_data);
                    pending <= 1'b1;
                end
            end else if (grant) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcount       <= '0;
            lane_timeout <= 1'b0;
        end else begin
            if (valid_sync) begin
                tcount <= '0;
            end else if (tick && (tcount != 16'hFFFF)) begin
                tcount <= tcount + 16'd1;
            end
            lane_timeout <= !valid_sync && (timeout_limit != 16'd0) && (tcount >= timeout_limit);
        end
    end

endmodule

// File: rtl/ts_hdr_scheduler.sv
// Multi-lane TS header front end: per-lane capture feeding a round-robin
// arbiter into a single valid/ready header stream tagged with the lane index.
module ts_hdr_scheduler
    import ts_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_LANES-1:0] in_data,
    input  logic [NUM_LANES-1:0]   in_valid,
    input  logic [NUM_LANES-1:0]   in_sync,
    input  logic                   tick,
    input  logic [15:0]            timeout_limit,
    output logic                   hdr_valid,
    input  logic                   hdr_ready,
    output logic [LANE_W-1:0]      hdr_lane,
    output logic                   hdr_tei,
    output logic                   hdr_pusi,
    output logic                   hdr_prio,
    output logic [12:0]            hdr_pid,
    output logic [1:0]             hdr_tsc,
    output logic [1:0]             hdr_afc,
    output logic [3:0]             hdr_cc,
    output logic [NUM_LANES-1:0]   sync_err,
    output logic [NUM_LANES-1:0]   overflow,
    output logic [NUM_LANES-1:0]   lane_timeout
);

    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] grant;
    ts_hdr_t              hold [NUM_LANES];
    ts_hdr_t              out_q;
    logic [LANE_W-1:0]    rr_ptr;
    logic [LANE_W-1:0]    idx;
    logic [LANE_W-1:0]    gidx;
    logic                 found;
    logic                 do_grant;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        ts_hdr_capture u_cap (
            .clk          (clk),
            .rst          (rst),
            .in_data      (in_data[8*i +: 8]),
            .in_valid     (in_valid[i]),
            .in_sync      (in_sync[i]),
            .tick         (tick),
            .timeout_limit(timeout_limit),
            .grant        (grant[i]),
            .pending      (pending[i]),
            .hdr          (hold[i]),
            .sync_err     (sync_err[i]),
            .overflow     (overflow[i]),
            .lane_timeout (lane_timeout[i])
        );
    end

    // Walk the lanes starting at rr_ptr, wrapping explicitly so any lane count works.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = rr_ptr;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!found && pending[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
            idx = (idx == LANE_W'(NUM_LANES - 1)) ? '0 : idx + LANE_W'(1);
        end
    end

    assign do_grant = found && (!hdr_valid || hdr_ready);

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            grant[i] = do_grant && (gidx == LANE_W'(i));
        end
    end

    // Output only changes on a grant or a completed handshake, so it never retracts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_valid <= 1'b0;
            hdr_lane  <= '0;
            out_q     <= '0;
            rr_ptr    <= '0;
        end else if (do_grant) begin
            hdr_valid <= 1'b1;
            hdr_lane  <= gidx;
            out_q     <= hold[gidx];
            rr_ptr    <= (gidx == LANE_W'(NUM_LANES - 1)) ? '0 : gidx + LANE_W'(1);
        end else if (hdr_ready) begin
            hdr_valid <= 1'b0;
        end
    end

    assign hdr_tei  = out_q.tei;
    assign hdr_pusi = out_q.pusi;
    assign hdr_prio = out_q.prio;
    assign hdr_pid  = out_q.pid;
    assign hdr_tsc  = out_q.tsc;
    assign hdr_afc  = out_q.afc;
    assign hdr_cc   = out_q.cc;

endmodule

// File: tb/tb_ts_hdr_scheduler.sv
// Directed self-checking bench for ts_hdr_scheduler (4 lanes).
module tb_ts_hdr_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_sync;
    logic        tick;
    logic [15:0] timeout_limit;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [1:0]  hdr_lane;
    logic        hdr_tei;
    logic        hdr_pusi;
    logic        hdr_prio;
    logic [12:0] hdr_pid;
    logic [1:0]  hdr_tsc;
    logic [1:0]  hdr_afc;
    logic [3:0]  hdr_cc;
    logic [3:0]  sync_err;
    logic [3:0]  overflow;
    logic [3:0]  lane_timeout;

    int total;
    int bad;

    ts_hdr_scheduler #(.NUM_LANES(4), .LANE_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_sync      (in_sync),
        .tick         (tick),
        .timeout_limit(timeout_limit),
        .hdr_valid    (hdr_valid),
        .hdr_ready    (hdr_ready),
        .hdr_lane     (hdr_lane),
        .hdr_tei      (hdr_tei),
        .hdr_pusi     (hdr_pusi),
        .hdr_prio     (hdr_prio),
        .hdr_pid      (hdr_pid),
        .hdr_tsc      (hdr_tsc),
        .hdr_afc      (hdr_afc),
        .hdr_cc       (hdr_cc),
        .sync_err     (sync_err),
        .overflow     (overflow),
        .lane_timeout (lane_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lane_beat(input int lane, input logic [7:0] d, input logic s);
        in_data[8*lane +: 8] = d;
        in_valid[lane]       = 1'b1;
        in_sync[lane]        = s;
        step();
        in_valid = '0;
        in_sync  = '0;
    endtask

    task automatic send_hdr(input int lane, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3);
        lane_beat(lane, 8'h47, 1'b1);
        lane_beat(lane, b1, 1'b0);
        lane_beat(lane, b2, 1'b0);
        lane_beat(lane, b3, 1'b0);
    endtask

    task automatic all_beat(input logic [31:0] d, input logic s);
        in_data  = d;
        in_valid = 4'hF;
        in_sync  = {4{s}};
        step();
        in_valid = '0;
        in_sync  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        in_data       = '0;
        in_valid      = '0;
        in_sync       = '0;
        tick          = 1'b0;
        timeout_limit = '0;
        hdr_ready     = 1'b0;
        #3;
        total++;
        if ({hdr_valid, hdr_lane, hdr_pid, hdr_cc, hdr_afc, hdr_tsc, hdr_tei, hdr_pusi, hdr_prio} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_hdr: got valid=%b lane=%0d pid=%h want all 0", hdr_valid, hdr_lane, hdr_pid);
        end
        total++;
        if ({sync_err, overflow, lane_timeout} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %h want 000", {sync_err, overflow, lane_timeout});
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_hdr(0, 8'h1F, 8'hFF, 8'h1A);
        total++;
        if (hdr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_early: got valid=%b want 0", hdr_valid);
        end
        step();
        total++;
        if ({hdr_valid, hdr_lane, hdr_pid, hdr_afc, hdr_cc} !== {1'b1, 2'd0, 13'h1FFF, 2'b01, 4'hA}) begin
            bad++;
            $display("[TB] FAIL basic_hdr: got valid=%b lane=%0d pid=%h afc=%b cc=%h want 1 0 1fff 01 a",
                     hdr_valid, hdr_lane, hdr_pid, hdr_afc, hdr_cc);
        end
        total++;
        if ({hdr_tei, hdr_pusi, hdr_prio, hdr_tsc} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL basic_flags: got %b want 00000", {hdr_tei, hdr_pusi, hdr_prio, hdr_tsc});
        end
        for (int i = 0; i < 3; i++) step();
        total++;
        if ({hdr_valid, hdr_pid, hdr_cc} !== {1'b1, 13'h1FFF, 4'hA}) begin
            bad++;
            $display("[TB] FAIL basic_hold: got valid=%b pid=%h cc=%h want 1 1fff a", hdr_valid, hdr_pid, hdr_cc);
        end
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        total++;
        if (hdr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_drop: got valid=%b want 0", hdr_valid);
        end
    endtask

    task automatic test_back_to_back();
        int first;
        do_reset();
        hdr_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            first = (r == 0) ? 0 : 2;
            if (r == 1) begin
                send_hdr(1, 8'h00, 8'h09, 8'h19);
                step();
                total++;
                if ({hdr_valid, hdr_lane, hdr_pid} !== {1'b1, 2'd1, 13'h009}) begin
                    bad++;
                    $display("[TB] FAIL rr_setup: got valid=%b lane=%0d pid=%h want 1 1 009", hdr_valid, hdr_lane, hdr_pid);
                end
                step();
            end
            all_beat(32'h47474747, 1'b1);
            all_beat(32'h00000000, 1'b0);
            all_beat(32'h03020100, 1'b0);
            all_beat(32'h13121110, 1'b0);
            for (int k = 0; k < 4; k++) begin
                step();
                total++;
                if ({hdr_valid, hdr_lane, hdr_pid, hdr_afc, hdr_cc} !==
                    {1'b1, 2'((first + k) % 4), 13'((first + k) % 4), 2'b01, 4'((first + k) % 4)}) begin
                    bad++;
                    $display("[TB] FAIL rr_order r%0d k%0d: got valid=%b lane=%0d pid=%h cc=%h want lane %0d",
                             r, k, hdr_valid, hdr_lane, hdr_pid, hdr_cc, (first + k) % 4);
                end
            end
            step();
            total++;
            if (hdr_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rr_empty r%0d: got valid=%b want 0", r, hdr_valid);
            end
        end
        hdr_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        hdr_ready = 1'b0;
        send_hdr(0, 8'h00, 8'h05, 8'h10);
        step();
        send_hdr(1, 8'h00, 8'h21, 8'h11);
        total++;
        if (overflow !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL ovf_first: got %b want 0000", overflow);
        end
        send_hdr(1, 8'h00, 8'h22, 8'h12);
        total++;
        if (overflow !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL ovf_pulse: got %b want 0010", overflow);
        end
        step();
        total++;
        if (overflow !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL ovf_clear: got %b want 0000", overflow);
        end
        total++;
        if ({hdr_valid, hdr_lane, hdr_pid} !== {1'b1, 2'd0, 13'h005}) begin
            bad++;
            $display("[TB] FAIL ovf_out0: got valid=%b lane=%0d pid=%h want 1 0 005", hdr_valid, hdr_lane, hdr_pid);
        end
        hdr_ready = 1'b1;
        step();
        total++;
        if ({hdr_valid, hdr_lane, hdr_pid, hdr_afc, hdr_cc} !== {1'b1, 2'd1, 13'h021, 2'b01, 4'h1}) begin
            bad++;
            $display("[TB] FAIL ovf_kept: got valid=%b lane=%0d pid=%h cc=%h want 1 1 021 1",
                     hdr_valid, hdr_lane, hdr_pid, hdr_cc);
        end
        step();
        total++;
        if (hdr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_drained: got valid=%b want 0", hdr_valid);
        end
        hdr_ready = 1'b0;
    endtask

    task automatic test_sync();
        lane_beat(2, 8'h48, 1'b1);
        total++;
        if (sync_err !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL sync_err_pulse: got %b want 0100", sync_err);
        end
        lane_beat(2, 8'h11, 1'b0);
        total++;
        if (sync_err !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL sync_err_clear: got %b want 0000", sync_err);
        end
        lane_beat(2, 8'h22, 1'b0);
        lane_beat(2, 8'h33, 1'b0);
        step();
        step();
        total++;
        if (hdr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sync_idle_ignore: got valid=%b want 0", hdr_valid);
        end
        lane_beat(2, 8'h47, 1'b1);
        lane_beat(2, 8'h00, 1'b0);
        lane_beat(2, 8'h47, 1'b1);
        total++;
        if (sync_err !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL sync_resync_err: got %b want 0000", sync_err);
        end
        lane_beat(2, 8'h01, 1'b0);
        lane_beat(2, 8'h02, 1'b0);
        lane_beat(2, 8'h03, 1'b0);
        total++;
        if (hdr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sync_abort_none: got valid=%b want 0", hdr_valid);
        end
        step();
        total++;
        if ({hdr_valid, hdr_lane, hdr_pid, hdr_afc, hdr_cc} !== {1'b1, 2'd2, 13'h0102, 2'b00, 4'h3}) begin
            bad++;
            $display("[TB] FAIL sync_restart_hdr: got valid=%b lane=%0d pid=%h cc=%h want 1 2 0102 3",
                     hdr_valid, hdr_lane, hdr_pid, hdr_cc);
        end
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        total++;
        if (hdr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sync_single: got valid=%b want 0", hdr_valid);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        timeout_limit = 16'd3;
        tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick = 1'b0;
        total++;
        if (lane_timeout !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL to_early: got %b want 0000", lane_timeout);
        end
        step();
        total++;
        if (lane_timeout !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL to_set: got %b want 1111", lane_timeout);
        end
        lane_beat(3, 8'h47, 1'b1);
        total++;
        if (lane_timeout !== 4'b0111) begin
            bad++;
            $display("[TB] FAIL to_sync_clear: got %b want 0111", lane_timeout);
        end
        tick = 1'b1;
        lane_beat(0, 8'h47, 1'b1);
        tick = 1'b0;
        step();
        total++;
        if (lane_timeout !== 4'b0110) begin
            bad++;
            $display("[TB] FAIL to_coincide: got %b want 0110", lane_timeout);
        end
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        step();
        total++;
        if (lane_timeout !== 4'b1110) begin
            bad++;
            $display("[TB] FAIL to_clear_wins: got %b want 1110", lane_timeout);
        end
        timeout_limit = 16'd0;
        step();
        total++;
        if (lane_timeout !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL to_disable: got %b want 0000", lane_timeout);
        end
        tick = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tick = 1'b0;
        step();
        total++;
        if (lane_timeout !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL to_disabled_ticks: got %b want 0000", lane_timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hdr_ready = 1'b0;
        all_beat(32'h47474747, 1'b1);
        all_beat(32'h00000000, 1'b0);
        all_beat(32'h07060504, 1'b0);
        all_beat(32'h13121110, 1'b0);
        step();
        total++;
        if ({hdr_valid, hdr_lane, hdr_pid} !== {1'b1, 2'd0, 13'h004}) begin
            bad++;
            $display("[TB] FAIL rmid_pre: got valid=%b lane=%0d pid=%h want 1 0 004", hdr_valid, hdr_lane, hdr_pid);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({hdr_valid, hdr_lane, hdr_pid, hdr_cc, hdr_afc} !== '0) begin
            bad++;
            $display("[TB] FAIL rmid_clear: got valid=%b lane=%0d pid=%h cc=%h want all 0",
                     hdr_valid, hdr_lane, hdr_pid, hdr_cc);
        end
        #2;
        rst = 1'b1;
        step();
        hdr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (hdr_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rmid_stale%0d: got valid=%b lane=%0d want 0", i, hdr_valid, hdr_lane);
            end
        end
        hdr_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_sync();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
